// File: rtl/seg_scan_pkg.sv
// seg_scan shared definitions: BCD codes and active-low
// seven-segment glyphs, bit order {g,f,e,d,c,b,a}.
package seg_scan_pkg;

  localparam logic [3:0] BCD_ERR   = 4'hF;
  localparam logic [3:0] BCD_BLANK = 4'hA;

  localparam logic [6:0] SEG_D0    = 7'h40;
  localparam logic [6:0] SEG_D1    = 7'h79;
  localparam logic [6:0] SEG_D2    = 7'h24;
  localparam logic [6:0] SEG_D3    = 7'h30;
  localparam logic [6:0] SEG_D4    = 7'h19;
  localparam logic [6:0] SEG_D5    = 7'h12;
  localparam logic [6:0] SEG_D6    = 7'h02;
  localparam logic [6:0] SEG_D7    = 7'h78;
  localparam logic [6:0] SEG_D8    = 7'h00;
  localparam logic [6:0] SEG_D9    = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DEG   = 7'h1C;

endpackage

// File: rtl/seg_scan_decode.sv
// BCD code to active-low seven-segment glyph.
// 0-9 are digits, BCD_ERR is a dash, anything else is blank.
module seg7_decode
  import seg_scan_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_code)
      4'd0:    o_seg = SEG_D0;
      4'd1:    o_seg = SEG_D1;
      4'd2:    o_seg = SEG_D2;
      4'd3:    o_seg = SEG_D3;
      4'd4:    o_seg = SEG_D4;
      4'd5:    o_seg = SEG_D5;
      4'd6:    o_seg = SEG_D6;
      4'd7:    o_seg = SEG_D7;
      4'd8:    o_seg = SEG_D8;
      4'd9:    o_seg = SEG_D9;
      BCD_ERR: o_seg = SEG_DASH;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// Three-digit multiplexed LED scanner with a degree slot,
// frame-synchronous updates and anti-ghost blanking.
module seg_scan
  import seg_scan_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 16,
  parameter int LZ_BLANK    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] bcd0,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd2,
  input  logic       update,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLNK = CW'(BLANK_CYC);

  logic [CW-1:0]   r_count;
  logic [1:0]      r_idx;
  logic            r_pend;
  logic [2:0][3:0] r_pending;
  logic [2:0][3:0] r_disp;
  logic [6:0]      r_seg;
  logic [3:0]      r_an;
  logic            r_fd;

  logic       w_tick;
  logic       w_wrap;
  logic       w_blank;
  logic       w_err;
  logic       w_lz;
  logic [3:0] w_code;
  logic [6:0] w_dec;
  logic [6:0] w_seg;

  assign w_tick  = (r_count == LAST);
  assign w_wrap  = w_tick && (r_idx == 2'd3);
  assign w_blank = (r_count < BLNK);
  assign w_lz    = (LZ_BLANK != 0);
  assign w_err   = (r_disp[0] == BCD_ERR) ||
                   (r_disp[1] == BCD_ERR) ||
                   (r_disp[2] == BCD_ERR);

  // Suppressed leading zeros become an undefined code,
  // which the decoder renders blank.
  always_comb begin
    w_code = BCD_BLANK;
    unique case (r_idx)
      2'd0: w_code = r_disp[0];
      2'd1: w_code = (w_lz && r_disp[2] == 4'd0 &&
                      r_disp[1] == 4'd0) ?
                     BCD_BLANK : r_disp[1];
      2'd2: w_code = (w_lz && r_disp[2] == 4'd0) ?
                     BCD_BLANK : r_disp[2];
      default: w_code = BCD_BLANK;
    endcase
    if (w_err) w_code = BCD_ERR;
  end

  seg7_decode u_dec (
    .i_code (w_code),
    .o_seg  (w_dec)
  );

  assign w_seg = (r_idx == 2'd3) ? SEG_DEG : w_dec;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count   <= '0;
      r_idx     <= 2'd0;
      r_pend    <= 1'b0;
      r_pending <= {3{BCD_ERR}};
      r_disp    <= {3{BCD_ERR}};
      r_seg     <= SEG_BLANK;
      r_an      <= 4'hF;
      r_fd      <= 1'b0;
    end else begin
      r_count <= w_tick ? '0 : r_count + 1'b1;
      if (w_tick) r_idx <= r_idx + 2'd1;
      // Display only changes between frames.
      if (w_wrap) begin
        r_pend <= 1'b0;
        if (update)
          r_disp <= {bcd2, bcd1, bcd0};
        else if (r_pend)
          r_disp <= r_pending;
      end else if (update) begin
        r_pending <= {bcd2, bcd1, bcd0};
        r_pend    <= 1'b1;
      end
      r_an  <= w_blank ? 4'hF : ~(4'b0001 << r_idx);
      r_seg <= w_blank ? SEG_BLANK : w_seg;
      r_fd  <= w_wrap;
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign frame_done = r_fd;

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: frame-level model, directed
// literal pins, then randomized updates and resets.
module tb_seg_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       update = 1'b0;
  logic [3:0] bcd0 = 4'd0;
  logic [3:0] bcd1 = 4'd0;
  logic [3:0] bcd2 = 4'd0;
  logic [6:0] seg_a, seg_b;
  logic [3:0] an_a, an_b;
  logic       fd_a, fd_b;

  always #5 clk = ~clk;

  seg_scan #(.REFRESH_DIV(8), .BLANK_CYC(2), .LZ_BLANK(1)) u_lz (
    .clk(clk), .rst(rst), .bcd0(bcd0), .bcd1(bcd1),
    .bcd2(bcd2), .update(update), .seg(seg_a), .an(an_a),
    .frame_done(fd_a)
  );

  seg_scan #(.REFRESH_DIV(8), .BLANK_CYC(2), .LZ_BLANK(0)) u_nz (
    .clk(clk), .rst(rst), .bcd0(bcd0), .bcd1(bcd1),
    .bcd2(bcd2), .update(update), .seg(seg_b), .an(an_b),
    .frame_done(fd_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: t = cycles since reset; slot and phase follow
  // directly from t, display changes only at frame ends.
  int         t = 0;
  int         m_cnt, m_id;
  logic       m_valid = 1'b0;
  logic       m_pend;
  logic [3:0] m_pq [3];
  logic [3:0] m_dq [3];
  logic [6:0] exp_seg_a, exp_seg_b;
  logic [3:0] exp_an;
  logic       exp_fd;

  function automatic logic [6:0] digit_glyph(logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_glyph(int id, bit lz);
    if (id == 3) return 7'b0011100;
    if (m_dq[0] == 4'hF || m_dq[1] == 4'hF ||
        m_dq[2] == 4'hF) return 7'b0111111;
    if (lz && id == 2 && m_dq[2] == 4'd0)
      return 7'b1111111;
    if (lz && id == 1 && m_dq[2] == 4'd0 && m_dq[1] == 4'd0)
      return 7'b1111111;
    return digit_glyph(m_dq[id]);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      t = 0;
      m_pend = 1'b0;
      for (int i = 0; i < 3; i++) begin
        m_pq[i] = 4'hF;
        m_dq[i] = 4'hF;
      end
      exp_seg_a = 7'h7F;
      exp_seg_b = 7'h7F;
      exp_an = 4'hF;
      exp_fd = 1'b0;
      m_valid = 1'b1;
    end else begin
      m_cnt = t % 8;
      m_id = (t / 8) % 4;
      if (m_cnt < 2) begin
        exp_an = 4'hF;
        exp_seg_a = 7'h7F;
        exp_seg_b = 7'h7F;
      end else begin
        exp_an = ~(4'b0001 << m_id);
        exp_seg_a = exp_glyph(m_id, 1'b1);
        exp_seg_b = exp_glyph(m_id, 1'b0);
      end
      exp_fd = (t % 32 == 31);
      if (t % 32 == 31) begin
        if (update) begin
          m_dq[0] = bcd0; m_dq[1] = bcd1; m_dq[2] = bcd2;
        end else if (m_pend) begin
          m_dq = m_pq;
        end
        m_pend = 1'b0;
      end else if (update) begin
        m_pq[0] = bcd0; m_pq[1] = bcd1; m_pq[2] = bcd2;
        m_pend = 1'b1;
      end
      t++;
    end
  end

  task automatic chk(string nm, logic [6:0] act,
                     logic [6:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0d)",
               nm, act, exp, t);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("seg_lz", seg_a, exp_seg_a);
      chk("seg_nz", seg_b, exp_seg_b);
      chk("an_lz", {3'b0, an_a}, {3'b0, exp_an});
      chk("an_nz", {3'b0, an_b}, {3'b0, exp_an});
      chk("fd_lz", {6'b0, fd_a}, {6'b0, exp_fd});
      chk("fd_nz", {6'b0, fd_b}, {6'b0, exp_fd});
    end
  end

  // Returns at the negedge where outputs show state n-1.
  task automatic wait_t(int n);
    int k = 0;
    while (t != n && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (t != n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_t: t=%0d expected %0d", t, n);
    end
  endtask

  task automatic upd(logic [3:0] h, logic [3:0] tn,
                     logic [3:0] u, int at);
    wait_t(at);
    bcd2 = h; bcd1 = tn; bcd0 = u;
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
  endtask

  function automatic logic [3:0] rnd_digit();
    int r;
    r = $urandom_range(0, 31);
    if (r < 8) return 4'd0;
    if (r < 26) return 4'($urandom_range(0, 9));
    if (r < 29) return 4'hF;
    return 4'($urandom_range(10, 14));
  endfunction

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_seg", seg_a, 7'h7F);
    chk("rst_an", {3'b0, an_a}, 7'h0F);
    rst = 1'b0;
    wait_t(2);
    chk("lit_blank_an", {3'b0, an_a}, 7'h0F);
    wait_t(3);
    chk("lit_an0", {3'b0, an_a}, 7'b0001110);
    chk("lit_dash", seg_a, 7'b0111111);
    wait_t(27);
    chk("lit_an3", {3'b0, an_a}, 7'b0000111);
    chk("lit_deg", seg_a, 7'h1C);
    wait_t(32);
    chk("lit_fd_hi", {6'b0, fd_a}, 7'd1);
    wait_t(33);
    chk("lit_fd_lo", {6'b0, fd_a}, 7'd0);
    upd(4'd3, 4'd5, 4'd9, 40);
    wait_t(43);
    chk("lit_no_tear", seg_a, 7'h3F);
    wait_t(67);
    chk("lit_u9", seg_a, 7'h10);
    wait_t(75);
    chk("lit_t5", seg_a, 7'h12);
    wait_t(83);
    chk("lit_h3", seg_a, 7'h30);
    upd(4'd0, 4'd0, 4'd5, 96);
    wait_t(131);
    chk("lit_u5", seg_a, 7'h12);
    wait_t(139);
    chk("lit_lz_t", seg_a, 7'h7F);
    chk("lit_nz_t", seg_b, 7'h40);
    wait_t(147);
    chk("lit_lz_h", seg_a, 7'h7F);
    chk("lit_nz_h", seg_b, 7'h40);
    upd(4'hF, 4'hF, 4'hF, 160);
    wait_t(195);
    chk("lit_err", seg_a, 7'h3F);
    wait_t(219);
    chk("lit_err_deg", seg_a, 7'h1C);
    upd(4'd3, 4'd2, 4'd1, 224);
    upd(4'd7, 4'd0, 4'd1, 240);
    wait_t(259);
    chk("lit_last_u", seg_a, 7'h79);
    wait_t(267);
    chk("lit_last_t", seg_a, 7'h40);
    wait_t(275);
    chk("lit_last_h", seg_a, 7'h78);
    upd(4'd4, 4'd2, 4'd8, 287);
    wait_t(291);
    chk("lit_wrap_upd", seg_a, 7'h00);
    upd(4'd6, 4'd6, 4'd6, 330);
    wait_t(338);
    rst = 1'b1;
    @(negedge clk);
    chk("lit_rst_seg", seg_a, 7'h7F);
    chk("lit_rst_an", {3'b0, an_a}, 7'h0F);
    chk("lit_rst_fd", {6'b0, fd_a}, 7'd0);
    rst = 1'b0;
    wait_t(3);
    chk("lit_rst_dash", seg_a, 7'h3F);
    wait_t(67);
    chk("lit_discard", seg_a, 7'h3F);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 499) == 0);
      update = ($urandom_range(0, 5) == 0);
      bcd0 = rnd_digit();
      bcd1 = rnd_digit();
      bcd2 = rnd_digit();
    end
    @(negedge clk);
    rst = 1'b0;
    update = 1'b0;
    repeat (40) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
